// File: rtl/rob_multi_commit_pkg.sv
// rob_multi_commit_pkg: shared reorder-buffer types.
// p_reg, ROB row format and commit slot format.
package rob_multi_commit_pkg;

  localparam int P_REG_W = 7;

  typedef logic [P_REG_W-1:0] p_reg;

  typedef struct packed {
    logic valid;
    p_reg PRegAddrDst;
    p_reg OldPRegAddrDst;
    logic complete;
  } rob_row_struct;

  typedef struct packed {
    logic valid;
    p_reg PRegAddrDst;
    p_reg OldPRegAddrDst;
  } commit_slot_struct;

  function automatic int rob_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// rob_commit_select: picks the contiguous run of
// valid+complete rows starting at the ROB head.
module rob_commit_select #(
  parameter int DEPTH        = 16,
  parameter int COMMIT_WIDTH = 2,
  localparam int IDX_W       = $clog2(DEPTH),
  localparam int CNT_W       = IDX_W + 1,
  localparam int NUM_W       = $clog2(COMMIT_WIDTH + 1)
)(
  input  logic [IDX_W-1:0]        head,
  input  logic [CNT_W-1:0]        count,
  input  logic [DEPTH-1:0]        row_valid,
  input  logic [DEPTH-1:0]        row_cpl,
  output logic [COMMIT_WIDTH-1:0] retire_mask,
  output logic [NUM_W-1:0]        retire_num
);

  // Walk from head; the first row not ready ends the run.
  always_comb begin
    logic             run;
    logic [IDX_W-1:0] row;
    retire_mask = '0;
    retire_num  = '0;
    run         = 1'b1;
    row         = head;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      row = head + IDX_W'(k);
      if (run && (CNT_W'(k) < count) &&
          row_valid[row] && row_cpl[row]) begin
        retire_mask[k] = 1'b1;
        retire_num     = retire_num + NUM_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: parametrised ROB, in-order alloc,
// any-order completion, up to COMMIT_WIDTH retires/cycle.
// Optional flush port: ROB_MULTI_COMMIT_FLUSH_EN.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int NUM_CPL      = 3,
  parameter int COMMIT_WIDTH = 2,
  parameter int PREG_W       = P_REG_W,
  localparam int ROB_IDX_W   = $clog2(DEPTH)
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [PREG_W-1:0]              disp_preg_dst,
  input  logic [PREG_W-1:0]              disp_old_preg_dst,
  output logic [ROB_IDX_W-1:0]           disp_rob_idx,
  input  logic [NUM_CPL-1:0]             cpl_valid,
  input  logic [NUM_CPL*ROB_IDX_W-1:0]   cpl_idx,
  output logic [COMMIT_WIDTH-1:0]        commit_valid,
  output logic [COMMIT_WIDTH*PREG_W-1:0] commit_preg_dst,
  output logic [COMMIT_WIDTH*PREG_W-1:0] commit_old_preg_dst,
  output logic                           rob_empty
`ifdef ROB_MULTI_COMMIT_FLUSH_EN
  ,
  input  logic                           flush
`endif
);

  localparam int PTR_W = ROB_IDX_W + 1;
  localparam int NUM_W = $clog2(COMMIT_WIDTH + 1);

  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [PTR_W-1:0]        count;
  logic [ROB_IDX_W-1:0]    head_idx;
  logic [ROB_IDX_W-1:0]    tail_idx;
  logic [DEPTH-1:0]        row_valid;
  logic [DEPTH-1:0]        row_cpl;
  logic [PREG_W-1:0]       row_dst [DEPTH];
  logic [PREG_W-1:0]       row_old [DEPTH];
  logic [COMMIT_WIDTH-1:0] sel_mask;
  logic [COMMIT_WIDTH-1:0] ret_mask;
  logic [NUM_W-1:0]        sel_num;
  logic [NUM_W-1:0]        ret_num;
  logic                    kill;
  logic                    alloc;

  assign count        = tail - head;
  assign head_idx     = head[ROB_IDX_W-1:0];
  assign tail_idx     = tail[ROB_IDX_W-1:0];
  assign disp_ready   = (count != PTR_W'(DEPTH));
  assign disp_rob_idx = tail_idx;
  assign rob_empty    = (head == tail);

`ifdef ROB_MULTI_COMMIT_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign alloc        = disp_valid && disp_ready && !kill;
  assign ret_mask     = kill ? '0 : sel_mask;
  assign ret_num      = kill ? '0 : sel_num;
  assign commit_valid = ret_mask;

  rob_commit_select #(
    .DEPTH        (DEPTH),
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_sel (
    .head        (head_idx),
    .count       (count),
    .row_valid   (row_valid),
    .row_cpl     (row_cpl),
    .retire_mask (sel_mask),
    .retire_num  (sel_num)
  );

  // Head advances by retires; tail by alloc or snaps to head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + PTR_W'(ret_num);
      if (kill)
        tail <= head;
      else if (alloc)
        tail <= tail + PTR_W'(1);
    end
  end

  // Row status: completions set, retires clear, alloc opens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_valid <= '0;
      row_cpl   <= '0;
    end else if (kill) begin
      row_valid <= '0;
      row_cpl   <= '0;
    end else begin
      for (int p = 0; p < NUM_CPL; p++) begin
        if (cpl_valid[p] &&
            row_valid[cpl_idx[p*ROB_IDX_W +: ROB_IDX_W]])
          row_cpl[cpl_idx[p*ROB_IDX_W +: ROB_IDX_W]] <= 1'b1;
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (ret_mask[k]) begin
          row_valid[head_idx + ROB_IDX_W'(k)] <= 1'b0;
          row_cpl[head_idx + ROB_IDX_W'(k)]   <= 1'b0;
        end
      end
      if (alloc) begin
        row_valid[tail_idx] <= 1'b1;
        row_cpl[tail_idx]   <= 1'b0;
      end
    end
  end

  // Capture register mapping of each dispatched entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        row_dst[i] <= '0;
        row_old[i] <= '0;
      end
    end else if (alloc) begin
      row_dst[tail_idx] <= disp_preg_dst;
      row_old[tail_idx] <= disp_old_preg_dst;
    end
  end

  // Present retiring rows per slot; idle slots read zero.
  always_comb begin
    logic [ROB_IDX_W-1:0] r;
    commit_preg_dst     = '0;
    commit_old_preg_dst = '0;
    r                   = head_idx;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      r = head_idx + ROB_IDX_W'(k);
      if (ret_mask[k]) begin
        commit_preg_dst[k*PREG_W +: PREG_W]     = row_dst[r];
        commit_old_preg_dst[k*PREG_W +: PREG_W] = row_old[r];
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: directed scenarios plus random
// traffic against a sequence-number ROB model.
module tb_rob_multi_commit;

  localparam int DEPTH   = 16;
  localparam int NUM_CPL = 3;
  localparam int CW      = 2;
  localparam int PW      = 7;
  localparam int IW      = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               disp_valid;
  logic               disp_ready;
  logic [PW-1:0]      disp_preg_dst;
  logic [PW-1:0]      disp_old_preg_dst;
  logic [IW-1:0]      disp_rob_idx;
  logic [NUM_CPL-1:0] cpl_valid;
  logic [NUM_CPL*IW-1:0] cpl_idx;
  logic [CW-1:0]      commit_valid;
  logic [CW*PW-1:0]   commit_preg_dst;
  logic [CW*PW-1:0]   commit_old_preg_dst;
  logic               rob_empty;
  logic               flush = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rob_multi_commit #(
    .DEPTH(DEPTH), .NUM_CPL(NUM_CPL),
    .COMMIT_WIDTH(CW), .PREG_W(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .disp_valid(disp_valid),
    .disp_ready(disp_ready),
    .disp_preg_dst(disp_preg_dst),
    .disp_old_preg_dst(disp_old_preg_dst),
    .disp_rob_idx(disp_rob_idx),
    .cpl_valid(cpl_valid),
    .cpl_idx(cpl_idx),
    .commit_valid(commit_valid),
    .commit_preg_dst(commit_preg_dst),
    .commit_old_preg_dst(commit_old_preg_dst),
    .rob_empty(rob_empty)
`ifdef ROB_MULTI_COMMIT_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  // Model: entries keyed by sequence number mh..mt-1.
  logic          m_valid [DEPTH];
  logic          m_cpl   [DEPTH];
  logic [PW-1:0] m_dst   [DEPTH];
  logic [PW-1:0] m_old   [DEPTH];
  int            mh;
  int            mt;

  logic [CW-1:0]    exp_cv;
  logic [CW*PW-1:0] exp_dst;
  logic [CW*PW-1:0] exp_old;
  logic             exp_ready;
  logic             exp_empty;
  logic [IW-1:0]    exp_idx;

  function automatic void mdl_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_cpl[i]   = 1'b0;
      m_dst[i]   = '0;
      m_old[i]   = '0;
    end
    mh = 0;
    mt = 0;
  endfunction

  // Oldest entries retire in order while done, up to CW.
  function automatic int mdl_retire_n();
    int n = 0;
    while (n < CW && n < (mt - mh) &&
           m_valid[(mh + n) % DEPTH] &&
           m_cpl[(mh + n) % DEPTH])
      n++;
    return n;
  endfunction

  function automatic void mdl_expect();
    int n;
    n = flush ? 0 : mdl_retire_n();
    exp_cv  = '0;
    exp_dst = '0;
    exp_old = '0;
    for (int k = 0; k < n; k++) begin
      exp_cv[k] = 1'b1;
      exp_dst[k*PW +: PW] = m_dst[(mh + k) % DEPTH];
      exp_old[k*PW +: PW] = m_old[(mh + k) % DEPTH];
    end
    exp_ready = (mt - mh) < DEPTH;
    exp_idx   = IW'(mt % DEPTH);
    exp_empty = (mt == mh);
  endfunction

  function automatic void mdl_update();
    int n;
    int r;
    bit rdy;
    n   = flush ? 0 : mdl_retire_n();
    rdy = (mt - mh) < DEPTH;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 1'b0;
        m_cpl[i]   = 1'b0;
      end
      mt = mh;
      return;
    end
    for (int p = 0; p < NUM_CPL; p++) begin
      if (cpl_valid[p]) begin
        r = int'(cpl_idx[p*IW +: IW]);
        if (m_valid[r]) m_cpl[r] = 1'b1;
      end
    end
    for (int k = 0; k < n; k++) begin
      m_valid[(mh + k) % DEPTH] = 1'b0;
      m_cpl[(mh + k) % DEPTH]   = 1'b0;
    end
    mh += n;
    if (disp_valid && rdy) begin
      r = mt % DEPTH;
      m_valid[r] = 1'b1;
      m_cpl[r]   = 1'b0;
      m_dst[r]   = disp_preg_dst;
      m_old[r]   = disp_old_preg_dst;
      mt++;
    end
  endfunction

  task automatic idle();
    disp_valid        = 1'b0;
    disp_preg_dst     = '0;
    disp_old_preg_dst = '0;
    cpl_valid         = '0;
    cpl_idx           = '0;
    flush             = 1'b0;
  endtask

  task automatic disp(input logic [PW-1:0] d,
                      input logic [PW-1:0] o);
    idle();
    disp_valid        = 1'b1;
    disp_preg_dst     = d;
    disp_old_preg_dst = o;
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_update();
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_tests++;
    if (disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready got %0b want 1", disp_ready);
    end
    n_tests++;
    if (disp_rob_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_idx got %0d want 0", disp_rob_idx);
    end
    n_tests++;
    if (commit_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_cv got %b want 00", commit_valid);
    end
    n_tests++;
    if (commit_preg_dst !== '0 || commit_old_preg_dst !== '0) begin
      n_fail++;
      $display("FAIL rst_pregs got %h/%h want 0/0",
               commit_preg_dst, commit_old_preg_dst);
    end
    n_tests++;
    if (rob_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_empty got %0b want 1", rob_empty);
    end
    tick();
  endtask

  task automatic test_dispatch();
    for (int i = 0; i < 3; i++) begin
      disp(PW'(33 + i), PW'(1 + i));
      @(negedge clk);
      n_tests++;
      if (disp_rob_idx !== IW'(i) || disp_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL disp_idx%0d got %0d/%0b want %0d/1",
                 i, disp_rob_idx, disp_ready, i);
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_tests++;
    if (commit_valid !== 2'b00 || rob_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL disp_state got cv=%b empty=%0b want 00/0",
               commit_valid, rob_empty);
    end
    tick();
  endtask

  task automatic test_inorder();
    idle();
    cpl_valid = 3'b101;
    cpl_idx   = {4'd0, 4'd0, 4'd1};
    @(negedge clk);
    n_tests++;
    if (commit_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL io_cpl_cycle got %b want 00", commit_valid);
    end
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (commit_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL io_cv got %b want 11", commit_valid);
    end
    n_tests++;
    if (commit_old_preg_dst !== {7'd2, 7'd1} ||
        commit_preg_dst !== {7'd34, 7'd33}) begin
      n_fail++;
      $display("FAIL io_pregs got %h/%h want %h/%h",
               commit_old_preg_dst, commit_preg_dst,
               {7'd2, 7'd1}, {7'd34, 7'd33});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (commit_valid !== 2'b00 || rob_empty !== 1'b0 ||
        disp_rob_idx !== 4'd3) begin
      n_fail++;
      $display("FAIL io_head2 got cv=%b e=%0b idx=%0d want 00/0/3",
               commit_valid, rob_empty, disp_rob_idx);
    end
    tick();
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      disp(PW'(40 + i), PW'(i));
      @(negedge clk);
      n_tests++;
      if (disp_ready !== 1'b1 || disp_rob_idx !== IW'(i)) begin
        n_fail++;
        $display("FAIL fill%0d got %0b/%0d want 1/%0d",
                 i, disp_ready, disp_rob_idx, i);
      end
      tick();
    end
    disp(7'd99, 7'd99);
    @(negedge clk);
    n_tests++;
    if (disp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_17th got %0b want 0", disp_ready);
    end
    tick();
    cpl_valid = 3'b011;
    cpl_idx   = {4'd0, 4'd1, 4'd0};
    @(negedge clk);
    n_tests++;
    if (disp_ready !== 1'b0 || commit_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL full_cpl got %0b/%b want 0/00",
               disp_ready, commit_valid);
    end
    tick();
    cpl_valid = '0;
    @(negedge clk);
    n_tests++;
    if (disp_ready !== 1'b0 || commit_valid !== 2'b11 ||
        commit_old_preg_dst !== {7'd1, 7'd0}) begin
      n_fail++;
      $display("FAIL full_commit got %0b/%b/%h want 0/11/%h",
               disp_ready, commit_valid, commit_old_preg_dst,
               {7'd1, 7'd0});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (disp_ready !== 1'b1 || disp_rob_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_alloc got %0b/%0d want 1/0",
               disp_ready, disp_rob_idx);
    end
    tick();
    disp(7'd100, 7'd100);
    @(negedge clk);
    n_tests++;
    if (disp_ready !== 1'b1 || disp_rob_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_next got %0b/%0d want 1/1",
               disp_ready, disp_rob_idx);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (disp_ready !== 1'b0 || rob_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_full got %0b/%0b want 0/0",
               disp_ready, rob_empty);
    end
    tick();
    idle();
  endtask

  task automatic test_ooo();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      disp(PW'(50 + i), PW'(10 + i));
      tick();
    end
    idle();
    cpl_valid = 3'b111;
    cpl_idx   = {4'd9, 4'd1, 4'd0};
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (commit_valid !== 2'b11 ||
        commit_old_preg_dst !== {7'd11, 7'd10}) begin
      n_fail++;
      $display("FAIL ooo_first got %b/%h want 11/%h",
               commit_valid, commit_old_preg_dst, {7'd11, 7'd10});
    end
    tick();
    cpl_valid = 3'b001;
    cpl_idx   = {4'd0, 4'd0, 4'd3};
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (commit_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL ooo_wait got %b want 00", commit_valid);
    end
    tick();
    cpl_valid = 3'b010;
    cpl_idx   = {4'd0, 4'd2, 4'd0};
    @(negedge clk);
    n_tests++;
    if (commit_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL ooo_cpl2 got %b want 00", commit_valid);
    end
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (commit_valid !== 2'b11 ||
        commit_old_preg_dst !== {7'd13, 7'd12} ||
        commit_preg_dst !== {7'd53, 7'd52}) begin
      n_fail++;
      $display("FAIL ooo_pair got %b/%h/%h", commit_valid,
               commit_old_preg_dst, commit_preg_dst);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      disp(PW'(80 + i), PW'(40 + i));
      tick();
    end
    for (int j = 0; j < 6; j++) begin
      idle();
      if (4 + 2 * j <= 8) begin
        cpl_valid[0]    = 1'b1;
        cpl_idx[0 +: IW] = IW'(4 + 2 * j);
      end
      if (5 + 2 * j <= 8) begin
        cpl_valid[1]     = 1'b1;
        cpl_idx[IW +: IW] = IW'(5 + 2 * j);
      end
      @(negedge clk);
      mdl_expect();
      n_tests++;
      if (commit_valid !== exp_cv ||
          commit_old_preg_dst !== exp_old) begin
        n_fail++;
        $display("FAIL ooo_drain%0d got %b/%h want %b/%h", j,
                 commit_valid, commit_old_preg_dst, exp_cv, exp_old);
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_tests++;
    if (rob_empty !== 1'b0 || commit_valid !== 2'b00 ||
        disp_rob_idx !== 4'd10) begin
      n_fail++;
      $display("FAIL ooo_row9 got e=%0b cv=%b idx=%0d want 0/00/10",
               rob_empty, commit_valid, disp_rob_idx);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      disp(PW'(60 + i), PW'(20 + i));
      tick();
    end
    idle();
    cpl_valid = 3'b001;
    cpl_idx   = '0;
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (commit_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL rm_pre got %b want 01", commit_valid);
    end
    reset = 1'b1;
    #1;
    mdl_reset();
    n_tests++;
    if (disp_ready !== 1'b1 || disp_rob_idx !== 4'd0 ||
        rob_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_ctrl got %0b/%0d/%0b want 1/0/1",
               disp_ready, disp_rob_idx, rob_empty);
    end
    n_tests++;
    if (commit_valid !== 2'b00 || commit_preg_dst !== '0 ||
        commit_old_preg_dst !== '0) begin
      n_fail++;
      $display("FAIL rm_commit got %b/%h/%h want 00/0/0",
               commit_valid, commit_preg_dst, commit_old_preg_dst);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    disp(7'd70, 7'd30);
    @(negedge clk);
    n_tests++;
    if (disp_rob_idx !== 4'd0 || disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_next got %0d/%0b want 0/1",
               disp_rob_idx, disp_ready);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    int live;
    int r;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      disp_valid        = ($urandom_range(3) != 0);
      disp_preg_dst     = PW'($urandom);
      disp_old_preg_dst = PW'($urandom);
      live = mt - mh;
      for (int p = 0; p < NUM_CPL; p++) begin
        if ($urandom_range(c < 200 ? 3 : 1) == 0) begin
          cpl_valid[p] = 1'b1;
          if (live > 0 && $urandom_range(7) != 0)
            r = (mh + int'($urandom_range(live - 1))) % DEPTH;
          else
            r = int'($urandom_range(DEPTH - 1));
          cpl_idx[p*IW +: IW] = IW'(r);
        end
      end
      @(negedge clk);
      mdl_expect();
      n_tests++;
      if (commit_valid !== exp_cv) begin
        n_fail++;
        $display("FAIL rnd_cv c%0d got %b want %b",
                 c, commit_valid, exp_cv);
      end
      n_tests++;
      if (commit_preg_dst !== exp_dst) begin
        n_fail++;
        $display("FAIL rnd_dst c%0d got %h want %h",
                 c, commit_preg_dst, exp_dst);
      end
      n_tests++;
      if (commit_old_preg_dst !== exp_old) begin
        n_fail++;
        $display("FAIL rnd_old c%0d got %h want %h",
                 c, commit_old_preg_dst, exp_old);
      end
      n_tests++;
      if (disp_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rnd_ready c%0d got %0b want %0b",
                 c, disp_ready, exp_ready);
      end
      n_tests++;
      if (disp_rob_idx !== exp_idx) begin
        n_fail++;
        $display("FAIL rnd_idx c%0d got %0d want %0d",
                 c, disp_rob_idx, exp_idx);
      end
      n_tests++;
      if (rob_empty !== exp_empty) begin
        n_fail++;
        $display("FAIL rnd_empty c%0d got %0b want %0b",
                 c, rob_empty, exp_empty);
      end
      tick();
    end
    idle();
  endtask

`ifdef ROB_MULTI_COMMIT_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      disp(PW'(90 + i), PW'(60 + i));
      tick();
    end
    idle();
    cpl_valid = 3'b011;
    cpl_idx   = {4'd0, 4'd3, 4'd2};
    tick();
    disp(7'd99, 7'd98);
    flush = 1'b1;
    @(negedge clk);
    mdl_expect();
    n_tests++;
    if (commit_valid !== exp_cv || commit_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL fl_cycle got %b want 00", commit_valid);
    end
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (rob_empty !== 1'b1 || commit_valid !== 2'b00 ||
        disp_ready !== 1'b1 || disp_rob_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL fl_after got e=%0b cv=%b r=%0b idx=%0d",
               rob_empty, commit_valid, disp_ready, disp_rob_idx);
    end
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    mdl_reset();
    test_reset();
    test_dispatch();
    test_inorder();
    test_full();
    test_ooo();
    test_reset_mid();
    test_random();
`ifdef ROB_MULTI_COMMIT_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
